// File: rtl/rpu_wb_pkg.sv
// Shared types and lane helpers for the RPU-to-Wishbone bridge.
package rpu_wb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Size codes 10 and 11 both mean a full word.
   function automatic logic [3:0] sel_gen(input logic [1:0] size, input logic [1:0] a);
      case (size)
         SZ_BYTE: sel_gen = 4'b0001 << a;
         SZ_HALF: sel_gen = a[1] ? 4'b1100 : 4'b0011;
         default: sel_gen = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] wdata_rep(input logic [1:0] size, input logic [31:0] d);
      case (size)
         SZ_BYTE: wdata_rep = {4{d[7:0]}};
         SZ_HALF: wdata_rep = {2{d[15:0]}};
         default: wdata_rep = d;
      endcase
   endfunction

endpackage

// File: rtl/rpu_wb_lane_align.sv
// Steers the addressed byte/half lane of a Wishbone read word down to bit 0, zero-extended.
module rpu_wb_lane_align
   import rpu_wb_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_dat,
   output logic [31:0] o_dat
);

   always_comb begin
      o_dat = '0;
      case (i_size)
         SZ_BYTE: begin
            case (i_addr_lo)
               2'd0:    o_dat = {24'h0, i_dat[7:0]};
               2'd1:    o_dat = {24'h0, i_dat[15:8]};
               2'd2:    o_dat = {24'h0, i_dat[23:16]};
               default: o_dat = {24'h0, i_dat[31:24]};
            endcase
         end
         SZ_HALF: o_dat = i_addr_lo[1] ? {16'h0, i_dat[31:16]} : {16'h0, i_dat[15:0]};
         default: o_dat = i_dat;
      endcase
   end

endmodule

// File: rtl/rpu_wb_bridge.sv
// RPU native memory port to Wishbone classic bridge (IDLE -> BUS -> RESP).
// Optional bus watchdog enabled by defining RPU_WB_TIMEOUT_EN.
module rpu_wb_bridge
   import rpu_wb_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_cmd_i,
   input  logic              mem_we_i,
   input  logic [1:0]        mem_byte_enable_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic              mem_ready_o,
   output logic [DATA_W-1:0] mem_data_o,
   output logic              mem_data_ready_o,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [3:0]        wb_sel_o,
   output logic [ADDR_W-1:0] wb_adr_o,
   output logic [DATA_W-1:0] wb_dat_o,
   input  logic [DATA_W-1:0] wb_dat_i,
   input  logic              wb_ack_i,
   output logic              bus_err_o
);

   state_e            r_state;
   state_e            w_next;
   logic              w_idle;
   logic              w_bus;
   logic              w_resp;
   logic              w_accept;
   logic              w_expire;
   logic              r_we;
   logic [1:0]        r_size;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic [31:0]       w_rdata_aligned;

   rpu_wb_lane_align u_align (
      .i_size    (r_size),
      .i_addr_lo (r_addr[1:0]),
      .i_dat     (wb_dat_i),
      .o_dat     (w_rdata_aligned)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_idle = 1'b0;
      w_bus  = 1'b0;
      w_resp = 1'b0;
      case (r_state)
         IDLE: begin
            w_idle = 1'b1;
            if (mem_cmd_i) w_next = BUS;
         end
         BUS: begin
            w_bus = 1'b1;
            if (wb_ack_i || w_expire) w_next = RESP;
         end
         RESP: begin
            w_resp = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_accept = w_idle & mem_cmd_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we    <= 1'b0;
         r_size  <= SZ_BYTE;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_we    <= mem_we_i;
         r_size  <= mem_byte_enable_i;
         r_addr  <= mem_addr_i;
         r_wdata <= mem_data_i;
      end
   end

   // An ack in the same cycle as watchdog expiry takes priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          r_rdata <= '0;
      else if (w_bus && wb_ack_i && !r_we) r_rdata <= w_rdata_aligned;
      else if (w_bus && w_expire && !wb_ack_i) r_rdata <= 32'hFFFF_FFFF;
   end

`ifdef RPU_WB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout;

   assign w_expire = w_bus && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else if (w_accept) begin
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else if (w_bus) begin
         r_cnt <= r_cnt + 1'b1;
         if (w_expire && !wb_ack_i) r_timeout <= 1'b1;
      end
   end

   assign bus_err_o = w_resp & r_timeout;
`else
   logic w_unused_cfg;
   assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
   assign w_expire     = 1'b0;
   assign bus_err_o    = 1'b0;
`endif

   assign mem_ready_o      = w_idle;
   assign mem_data_ready_o = w_resp;
   assign mem_data_o       = r_rdata;

   // Bus outputs are forced low outside BUS so reset and idle look identical.
   assign wb_cyc_o = w_bus;
   assign wb_stb_o = w_bus;
   assign wb_we_o  = w_bus & r_we;
   assign wb_sel_o = w_bus ? sel_gen(r_size, r_addr[1:0]) : 4'b0000;
   assign wb_adr_o = w_bus ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
   assign wb_dat_o = w_bus ? wdata_rep(r_size, r_wdata) : '0;

endmodule

// File: tb/tb_rpu_wb_bridge.sv
// Scoreboard bench for rpu_wb_bridge: directed cases plus randomized transactions.
module tb_rpu_wb_bridge;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_cmd_i;
   logic        mem_we_i;
   logic [1:0]  mem_byte_enable_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_data_i;
   logic        mem_ready_o;
   logic [31:0] mem_data_o;
   logic        mem_data_ready_o;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_adr_o, wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        bus_err_o;

   rpu_wb_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .mem_cmd_i(mem_cmd_i), .mem_we_i(mem_we_i), .mem_byte_enable_i(mem_byte_enable_i),
      .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
      .mem_ready_o(mem_ready_o), .mem_data_o(mem_data_o), .mem_data_ready_o(mem_data_ready_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
      .bus_err_o(bus_err_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic        we;
   } bus_t;

   bus_t        bus_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] err_q[$];
   logic [31:0] exp_rdata = 32'h0;

   int          s_waits = 0;
   logic [31:0] s_dat = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: lane rules written as plain arithmetic.
   function automatic logic [3:0] m_sel(input logic [1:0] size, input logic [1:0] a);
      if (size == 2'd0) return 4'(1 << a);
      if (size == 2'd1) return a[1] ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wdat(input logic [1:0] size, input logic [31:0] d);
      if (size == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
      if (size == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] m_rdat(input logic [1:0] size, input logic [1:0] a,
                                          input logic [31:0] x);
      if (size == 2'd0) return (x >> (8 * a)) & 32'hFF;
      if (size == 2'd1) return (x >> (16 * a[1])) & 32'hFFFF;
      return x;
   endfunction

   // Slave: ack after s_waits wait states; garbage on the data lines otherwise.
   int s_cnt = 0;
   always @(negedge clk) begin
      if (wb_cyc_o) begin
         if (s_cnt == s_waits) begin
            wb_ack_i = 1'b1;
            wb_dat_i = s_dat;
         end else begin
            wb_ack_i = 1'b0;
            wb_dat_i = $urandom;
         end
         s_cnt++;
      end else begin
         wb_ack_i = 1'b0;
         wb_dat_i = $urandom;
         s_cnt    = 0;
      end
   end

   // Bus monitor: every cyc cycle must match the pending expected bus item.
   logic in_bus = 1'b0;
   always @(negedge clk) begin
      if (wb_cyc_o) begin
         if (bus_q.size() == 0) begin
            chk("unexpected_bus_cycle", 32'(wb_cyc_o), 32'h0);
         end else begin
            chk("wb_stb", 32'(wb_stb_o), 32'h1);
            chk("wb_adr", wb_adr_o, bus_q[0].adr);
            chk("wb_sel", 32'(wb_sel_o), 32'(bus_q[0].sel));
            chk("wb_we", 32'(wb_we_o), 32'(bus_q[0].we));
            if (bus_q[0].we) chk("wb_dat", wb_dat_o, bus_q[0].dat);
         end
         in_bus = 1'b1;
      end else if (in_bus) begin
         in_bus = 1'b0;
         if (bus_q.size() > 0) void'(bus_q.pop_front());
      end
   end

   // Response monitor: every completion pulse pops one expected result.
   always @(negedge clk) begin
      if (mem_data_ready_o) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_data_ready", 32'(mem_data_ready_o), 32'h0);
         end else begin
            chk("mem_data_o", mem_data_o, exp_q.pop_front());
            chk("bus_err_o", 32'(bus_err_o), err_q.pop_front());
         end
      end
   end

   task automatic wait_ready();
      int t = 0;
      while (!mem_ready_o && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("ready_wait", 32'(mem_ready_o), 32'h1);
   endtask

   task automatic do_txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input int waits, input logic [31:0] rdata,
                         input logic hold);
      bus_t b;
      logic timed;
      int   lat, lim, n;
      wait_ready();
      s_waits = waits;
      s_dat   = rdata;
      b.adr = addr & 32'hFFFF_FFFC;
      b.sel = m_sel(size, addr[1:0]);
      b.dat = m_wdat(size, wdata);
      b.we  = we;
      bus_q.push_back(b);
`ifdef RPU_WB_TIMEOUT_EN
      timed = (waits >= TO);
`else
      timed = 1'b0;
`endif
      if (timed)   exp_rdata = 32'hFFFF_FFFF;
      else if (!we) exp_rdata = m_rdat(size, addr[1:0], rdata);
      exp_q.push_back(exp_rdata);
      err_q.push_back(32'(timed));
      lat = timed ? TO + 1 : waits + 2;
      lim = lat + 10;
      mem_cmd_i         = 1'b1;
      mem_we_i          = we;
      mem_byte_enable_i = size;
      mem_addr_i        = addr;
      mem_data_i        = wdata;
      @(negedge clk);
      n = 1;
      if (!hold) mem_cmd_i = 1'b0;
      chk("cyc_rise", 32'(wb_cyc_o), 32'h1);
      while (!mem_data_ready_o && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("latency", 32'(n), 32'(lat));
      mem_cmd_i = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      mem_cmd_i = 1'b0; mem_we_i = 1'b0; mem_byte_enable_i = 2'd0;
      mem_addr_i = 32'h0; mem_data_i = 32'h0;
      wb_ack_i = 1'b0; wb_dat_i = 32'h0;
      #13;
      chk("rst_ready", 32'(mem_ready_o), 32'h1);
      chk("rst_cyc", 32'(wb_cyc_o), 32'h0);
      chk("rst_stb", 32'(wb_stb_o), 32'h0);
      chk("rst_we", 32'(wb_we_o), 32'h0);
      chk("rst_sel", 32'(wb_sel_o), 32'h0);
      chk("rst_adr", wb_adr_o, 32'h0);
      chk("rst_dat", wb_dat_o, 32'h0);
      chk("rst_data_o", mem_data_o, 32'h0);
      chk("rst_data_ready", 32'(mem_data_ready_o), 32'h0);
      chk("rst_bus_err", 32'(bus_err_o), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", 32'(mem_ready_o), 32'h1);

      // Word read, zero-wait slave.
      do_txn(1'b0, 2'd2, 32'h100, 32'h0, 0, 32'hCAFE_BABE, 1'b0);
      // Byte write to lane 3.
      do_txn(1'b1, 2'd0, 32'h203, 32'h5A, 0, 32'h0, 1'b0);
      // Half read of the upper lane after three wait states.
      do_txn(1'b0, 2'd1, 32'h302, 32'h0, 3, 32'hBEEF_1234, 1'b0);
      // Misaligned half and word reads ignore the low address bits.
      do_txn(1'b0, 2'd1, 32'h401, 32'h0, 1, 32'h1122_3344, 1'b0);
      do_txn(1'b0, 2'd3, 32'h507, 32'h0, 2, 32'h8765_4321, 1'b0);

      // Command held high through the whole transaction: one bus cycle only.
      do_txn(1'b1, 2'd1, 32'h600, 32'hABCD, 2, 32'h0, 1'b1);
      repeat (3) @(negedge clk);
      chk("hold_no_second_cycle", 32'(wb_cyc_o), 32'h0);
      chk("hold_ready_again", 32'(mem_ready_o), 32'h1);
      do_txn(1'b0, 2'd0, 32'h601, 32'h0, 0, 32'h0000_7700, 1'b0);

      // Reset in the middle of a bus cycle.
      wait_ready();
      s_waits = 1000;
      mem_cmd_i = 1'b1; mem_we_i = 1'b0; mem_byte_enable_i = 2'd2;
      mem_addr_i = 32'h700; mem_data_i = 32'h0;
      bus_q.push_back('{adr: 32'h700, sel: 4'hF, dat: 32'h0, we: 1'b0});
      @(negedge clk);
      mem_cmd_i = 1'b0;
      chk("pre_rst_cyc", 32'(wb_cyc_o), 32'h1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_cyc", 32'(wb_cyc_o), 32'h0);
      chk("async_rst_stb", 32'(wb_stb_o), 32'h0);
      chk("async_rst_ready", 32'(mem_ready_o), 32'h1);
      @(negedge clk);
      chk("rst_no_data_ready", 32'(mem_data_ready_o), 32'h0);
      rst = 1'b0;
      exp_rdata = 32'h0;
      @(negedge clk);
      chk("rst_no_data_ready2", 32'(mem_data_ready_o), 32'h0);
      chk("post_rst_data_o", mem_data_o, 32'h0);

`ifdef RPU_WB_TIMEOUT_EN
      // Slave never acks: watchdog completes the transaction.
      do_txn(1'b0, 2'd2, 32'h800, 32'h0, 1000, 32'h0, 1'b0);
`endif

      for (int i = 0; i < 60; i++) begin
         do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                $urandom, $urandom_range(0, 3), $urandom, 1'b0);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
      chk("bus_q_drained", 32'(bus_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
